// File: rtl/pulse_train_sequencer.sv
// pulse_train_sequencer
//
// Purpose:
//   Programmable pulse-train controller. A start strobe latches the timing
//   configuration and runs one shared phase counter through a DELAY phase,
//   then alternating HIGH/LOW phases, for n_pulses pulses. A train with a
//   nonzero pulse count ends with a one-cycle done strobe. With
//   n_pulses = 0 the train runs until abort. Every phase lasts limit+1
//   cycles, where limit is the latched length field for that phase.
//
// Configuration macro:
//   PULSE_TRAIN_RETRIGGER_EN - when defined, start while busy (without
//   abort) restarts the train from a fresh DELAY phase with newly latched
//   configuration. When undefined, start while busy is ignored.
//
// Parameters:
//   WIDTH      width of delay/high_len/low_len and of the phase counter
//   CNT_WIDTH  width of n_pulses and pulses_sent
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   start        launch request
//   abort        stop the running train immediately (no done strobe)
//   delay        pre-train delay length (delay+1 cycles)
//   high_len     pulse high length (high_len+1 cycles)
//   low_len      inter-pulse low length (low_len+1 cycles)
//   n_pulses     pulses per train, 0 = continuous
//   busy         high in DELAY/HIGH/LOW
//   pulse_out    high only in HIGH
//   done         one-cycle strobe on normal completion
//   pulses_sent  completed pulses in current/last train

module pulse_train_sequencer #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     delay,
  input  logic [WIDTH-1:0]     high_len,
  input  logic [WIDTH-1:0]     low_len,
  input  logic [CNT_WIDTH-1:0] n_pulses,
  output logic                 busy,
  output logic                 pulse_out,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pulses_sent
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [WIDTH-1:0]     PH_ONE  = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic [2:0]           state;
  logic [WIDTH-1:0]     phase_cnt;
  logic [WIDTH-1:0]     sh_delay;
  logic [WIDTH-1:0]     sh_high;
  logic [WIDTH-1:0]     sh_low;
  logic [CNT_WIDTH-1:0] sh_n;
  logic [WIDTH-1:0]     limit;
  logic [CNT_WIDTH-1:0] sent_next;
  logic                 phase_end;
  logic                 in_train;
  logic                 load_train;

  // Select the latched length that governs the current phase; the counter
  // is compared for equality only and is cleared on every state change,
  // so it never runs past the selected limit.
  always_comb begin
    limit = sh_delay;
    case (state)
      ST_HIGH: limit = sh_high;
      ST_LOW:  limit = sh_low;
      default: limit = sh_delay;
    endcase
  end

  assign phase_end = (phase_cnt == limit);
  assign sent_next = pulses_sent + CNT_ONE;
  assign in_train  = (state == ST_DELAY) || (state == ST_HIGH) || (state == ST_LOW);

  // A train is (re)launched from IDLE on start. In the retrigger build a
  // start during a running train also relaunches it, but abort wins.
  always_comb begin
    load_train = 1'b0;
    if (state == ST_IDLE && start) begin
      load_train = 1'b1;
    end
`ifdef PULSE_TRAIN_RETRIGGER_EN
    if (in_train && start && !abort) begin
      load_train = 1'b1;
    end
`endif
  end

  // Main sequencer: reset first, then launch, then abort, then the
  // phase-end transitions. The shadow registers are only written on a
  // launch so input changes during a train have no effect on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      sh_delay    <= '0;
      sh_high     <= '0;
      sh_low      <= '0;
      sh_n        <= '0;
      pulses_sent <= '0;
    end else if (load_train) begin
      state       <= ST_DELAY;
      phase_cnt   <= '0;
      sh_delay    <= delay;
      sh_high     <= high_len;
      sh_low      <= low_len;
      sh_n        <= n_pulses;
      pulses_sent <= '0;
    end else begin
      case (state)
        ST_DELAY, ST_HIGH, ST_LOW: begin
          if (abort) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
          end else if (phase_end) begin
            phase_cnt <= '0;
            case (state)
              ST_DELAY: state <= ST_HIGH;
              ST_HIGH: begin
                pulses_sent <= sent_next;
                // The last pulse goes straight to DONE, skipping its LOW.
                if (sh_n != CNT_ZERO && sent_next == sh_n) begin
                  state <= ST_DONE;
                end else begin
                  state <= ST_LOW;
                end
              end
              default: state <= ST_HIGH;
            endcase
          end else begin
            phase_cnt <= phase_cnt + PH_ONE;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          phase_cnt <= '0;
        end
        ST_IDLE: begin
          phase_cnt <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only so they are glitch-free.
  assign busy      = in_train;
  assign pulse_out = (state == ST_HIGH);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb_pulse_train_sequencer
//
// Purpose:
//   Self-checking bench for pulse_train_sequencer. A table of per-cycle
//   vectors covers the reference train, hand-written sequences cover the
//   multi-cycle corner cases and a randomized run is compared against an
//   arithmetic reference model that derives the outputs from the time
//   elapsed since the last accepted start.
//
// Ports: none (top-level bench).

module tb_pulse_train_sequencer;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  delay;
  logic [WIDTH-1:0]  high_len;
  logic [WIDTH-1:0]  low_len;
  logic [CW-1:0]     n_pulses;
  logic              busy;
  logic              pulse_out;
  logic              done;
  logic [CW-1:0]     pulses_sent;

  int n_checks = 0;
  int n_fails  = 0;

  pulse_train_sequencer #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .delay(delay),
    .high_len(high_len),
    .low_len(low_len),
    .n_pulses(n_pulses),
    .busy(busy),
    .pulse_out(pulse_out),
    .done(done),
    .pulses_sent(pulses_sent)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: edge count, whether a train is in flight, the
  // edge it was launched on, its latched config and the held pulse count.
  int  ec = 0;
  bit  m_act = 0;
  int  m_t0 = 0;
  int  md = 0, mh = 0, ml = 0, mn = 0;
  int  m_hold = 0;

  // Phase category j cycles after the launch edge:
  // 0 idle, 1 delay, 2 high, 3 low, 4 done.
  function automatic int catOf(int j);
    int p, k, last_end;
    p = mh + ml + 2;
    if (j <= md) return 1;
    k = j - md - 1;
    if (mn != 0) begin
      last_end = (mn - 1) * p + mh + 1;
      if (k == last_end) return 4;
      if (k > last_end) return 0;
    end
    return ((k % p) <= mh) ? 2 : 3;
  endfunction

  // Completed pulse count j cycles after the launch edge.
  function automatic int psOf(int j);
    int p, k, c;
    p = mh + ml + 2;
    if (j <= md) return 0;
    k = j - md - 1;
    if (k < mh + 1) return 0;
    c = (k - mh - 1) / p + 1;
    if (mn != 0 && c > mn) c = mn;
    return c % (1 << CW);
  endfunction

  task automatic latchTrain();
    m_act = 1;
    m_t0  = ec;
    md    = int'(delay);
    mh    = int'(high_len);
    ml    = int'(low_len);
    mn    = int'(n_pulses);
  endtask

  // Advance the model by one edge using the inputs the DUT just sampled.
  task automatic modelEdge();
    int j, cat;
    j = ec - m_t0;
    ec++;
    if (reset) begin
      m_act  = 0;
      m_hold = 0;
    end else if (m_act) begin
      cat = catOf(j);
      if (cat >= 1 && cat <= 3) begin
        if (abort) begin
          m_act  = 0;
          m_hold = psOf(j);
        end
`ifdef PULSE_TRAIN_RETRIGGER_EN
        else if (start) begin
          latchTrain();
        end
`endif
      end else begin
        m_act  = 0;
        m_hold = psOf(j);
      end
    end else if (start) begin
      latchTrain();
    end
  endtask

  task automatic modelOut(output bit eb, output bit ep, output bit ed, output int eps);
    int cat;
    if (m_act) begin
      cat = catOf(ec - m_t0);
      eb  = (cat >= 1 && cat <= 3);
      ep  = (cat == 2);
      ed  = (cat == 4);
      eps = psOf(ec - m_t0);
    end else begin
      eb = 0; ep = 0; ed = 0; eps = m_hold;
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, ec, act, exp);
    end
  endtask

  // Compare all outputs against the reference model.
  task automatic checkOutput();
    bit eb, ep, ed;
    int eps;
    modelOut(eb, ep, ed, eps);
    checkVal("busy", int'(busy), int'(eb));
    checkVal("pulse_out", int'(pulse_out), int'(ep));
    checkVal("done", int'(done), int'(ed));
    checkVal("pulses_sent", int'(pulses_sent), eps);
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit rs,
                               input int d, input int h, input int l, input int n);
    start    = st;
    abort    = ab;
    reset    = rs;
    delay    = WIDTH'(d);
    high_len = WIDTH'(h);
    low_len  = WIDTH'(l);
    n_pulses = CW'(n);
  endtask

  // One clock: edge, model update, then sample away from the edge.
  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  typedef struct {
    bit st;
    int hl;
    bit eb;
    bit ep;
    bit ed;
    int eps;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int cnt_busy, cnt_pulse, cnt_done;
    bit saw_wrap;
    int prev_ps;

    // Reference train: delay=2, high=1, low=3, n=3. high_len is changed
    // to 5 mid-train and must not affect the running train.
    tbl[0]  = '{1, 1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 5, 1, 0, 0, 1};
    tbl[6]  = '{0, 5, 1, 0, 0, 1};
    tbl[7]  = '{0, 5, 1, 0, 0, 1};
    tbl[8]  = '{0, 5, 1, 0, 0, 1};
    tbl[9]  = '{0, 5, 1, 1, 0, 1};
    tbl[10] = '{0, 5, 1, 1, 0, 1};
    tbl[11] = '{0, 5, 1, 0, 0, 2};
    tbl[12] = '{0, 5, 1, 0, 0, 2};
    tbl[13] = '{0, 5, 1, 0, 0, 2};
    tbl[14] = '{0, 5, 1, 0, 0, 2};
    tbl[15] = '{0, 5, 1, 1, 0, 2};
    tbl[16] = '{0, 5, 1, 1, 0, 2};
    tbl[17] = '{0, 5, 0, 0, 1, 3};
    tbl[18] = '{0, 5, 0, 0, 0, 3};

    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    checkVal("reset_busy", int'(busy), 0);
    checkVal("reset_pulse", int'(pulse_out), 0);
    checkVal("reset_done", int'(done), 0);
    checkVal("reset_ps", int'(pulses_sent), 0);

    applyStimulus(0, 0, 0, 2, 1, 3, 3);
    stepCycle();
    checkOutput();

    // Table-driven reference train.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].st, 0, 0, 2, tbl[i].hl, 3, 3);
      stepCycle();
      checkVal($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
      checkVal($sformatf("tbl%0d_pulse", i), int'(pulse_out), int'(tbl[i].ep));
      checkVal($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].ed));
      checkVal($sformatf("tbl%0d_ps", i), int'(pulses_sent), tbl[i].eps);
    end

    // Next start picks up high_len=5: three 6-cycle pulses.
    cnt_pulse = 0;
    cnt_done  = 0;
    applyStimulus(1, 0, 0, 2, 5, 3, 3);
    stepCycle();
    checkOutput();
    applyStimulus(0, 0, 0, 2, 5, 3, 3);
    for (int i = 0; i < 35; i++) begin
      cnt_pulse += int'(pulse_out);
      stepCycle();
      checkOutput();
      cnt_done += int'(done);
    end
    checkVal("wide_pulse_cycles", cnt_pulse, 18);
    checkVal("wide_done_count", cnt_done, 1);

    // All lengths zero, single pulse.
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    cnt_busy = 0; cnt_pulse = 0; cnt_done = 0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      cnt_busy  += int'(busy);
      cnt_pulse += int'(pulse_out);
      cnt_done  += int'(done);
    end
    checkVal("zero_busy_cycles", cnt_busy, 2);
    checkVal("zero_pulse_cycles", cnt_pulse, 1);
    checkVal("zero_done_count", cnt_done, 1);

    // Continuous square wave with pulses_sent wrap, then abort mid-HIGH.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    saw_wrap = 0;
    prev_ps  = 0;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      checkOutput();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      if (prev_ps == 15 && int'(pulses_sent) == 0) saw_wrap = 1;
      prev_ps = int'(pulses_sent);
      cnt_done += int'(done);
    end
    checkVal("cont_wrap_seen", int'(saw_wrap), 1);
    for (int i = 0; i < 4 && pulse_out == 1'b0; i++) begin
      stepCycle();
      checkOutput();
    end
    checkVal("cont_high_before_abort", int'(pulse_out), 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput();
    checkVal("abort_pulse_low", int'(pulse_out), 0);
    checkVal("abort_busy_low", int'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput();
      cnt_done += int'(done);
    end
    checkVal("cont_no_done", cnt_done, 0);

    // Reset in LOW together with abort and start.
    applyStimulus(1, 0, 0, 0, 0, 5, 2);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 5, 2);
    stepCycle();
    stepCycle();
    checkOutput();
    applyStimulus(1, 1, 1, 0, 0, 5, 2);
    stepCycle();
    checkVal("rst_low_busy", int'(busy), 0);
    checkVal("rst_low_pulse", int'(pulse_out), 0);
    checkVal("rst_low_done", int'(done), 0);
    checkVal("rst_low_ps", int'(pulses_sent), 0);
    applyStimulus(0, 0, 0, 0, 0, 5, 2);
    stepCycle();
    checkOutput();

    // Start while busy: ignored in the base build, retrigger otherwise.
    applyStimulus(1, 0, 0, 1, 1, 1, 2);
    stepCycle();
    applyStimulus(0, 0, 0, 1, 1, 1, 2);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput();
    end
    applyStimulus(1, 0, 0, 3, 2, 0, 1);
    stepCycle();
    checkOutput();
    applyStimulus(0, 0, 0, 3, 2, 0, 1);
    for (int i = 0; i < 14; i++) begin
      stepCycle();
      checkOutput();
    end

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 199) == 0),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      stepCycle();
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
